// File: rtl/serial_pkg.sv
// Shared definitions for the serial bit source and the sequence detector it feeds.
// Holds the line-state encoding and the idle line level.
package serial_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StGap   = 2'd2
   } serial_state_e;

   localparam logic IdleLevel = 1'b0;

endpackage

// File: rtl/serial_bit_source.sv
// Parallel-to-serial stage: accepts words over valid/ready and emits one bit per clock
// on a registered line, with optional idle gap cycles after each word.
module serial_bit_source
   import serial_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned GAP       = 0,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy
);

   localparam int unsigned CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned HeadIdx = MSB_FIRST ? WIDTH - 1 : 0;
   localparam logic [CntW-1:0] BitInit = CntW'(WIDTH - 1);
   localparam logic [3:0]      GapInit = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   serial_state_e    state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CntW-1:0]  bitcnt_q, bitcnt_d;
   logic [3:0]       gapcnt_q, gapcnt_d;
   logic             sout_q, sout_d;
   logic             sout_valid_q, sout_valid_d;
   logic             busy_q, busy_d;
   logic             last_bit;
   logic             accept;

   assign last_bit  = (state_q == StShift) && (bitcnt_q == '0);
   // Only a gapless stream may take the next word on the last-bit cycle.
   assign din_ready = rst && ((state_q == StIdle) || (last_bit && (GAP == 0)));
   assign accept    = din_valid && din_ready;

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      gapcnt_d = gapcnt_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               shreg_d  = din;
               bitcnt_d = BitInit;
               state_d  = StShift;
            end
         end
         StShift: begin
            if (bitcnt_q != '0) begin
               shreg_d  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
               bitcnt_d = bitcnt_q - 1'b1;
            end else if (GAP != 0) begin
               gapcnt_d = GapInit;
               state_d  = StGap;
            end else if (accept) begin
               shreg_d  = din;
               bitcnt_d = BitInit;
            end else begin
               state_d = StIdle;
            end
         end
         StGap: begin
            if (gapcnt_q == '0) begin
               state_d = StIdle;
            end else begin
               gapcnt_d = gapcnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Outputs are registered from the next state so they line up with it.
      sout_valid_d = (state_d == StShift);
      sout_d       = sout_valid_d ? shreg_d[HeadIdx] : IdleLevel;
      busy_d       = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         shreg_q      <= '0;
         bitcnt_q     <= '0;
         gapcnt_q     <= '0;
         sout_q       <= IdleLevel;
         sout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bitcnt_q     <= bitcnt_d;
         gapcnt_q     <= gapcnt_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign sout       = sout_q;
   assign sout_valid = sout_valid_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_serial_bit_source.sv
// Directed bench for serial_bit_source: three instances (gapless MSB-first, GAP=2,
// LSB-first) checked cycle by cycle against a queue of expected {valid,sout,busy,ready}.
module tb_serial_bit_source;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] din_a [3];
   logic       dv    [3];
   logic       rd    [3];
   logic       so    [3];
   logic       sv    [3];
   logic       bz    [3];

   logic [3:0] sb [3][$];
   int         n_assert = 0;
   int         n_fail   = 0;
   int         cyc      = 0;

   always #5 clk = ~clk;

   serial_bit_source #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) dut0 (
      .clk(clk), .rst(rst), .din(din_a[0]), .din_valid(dv[0]), .din_ready(rd[0]),
      .sout(so[0]), .sout_valid(sv[0]), .busy(bz[0])
   );

   serial_bit_source #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst), .din(din_a[1]), .din_valid(dv[1]), .din_ready(rd[1]),
      .sout(so[1]), .sout_valid(sv[1]), .busy(bz[1])
   );

   serial_bit_source #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0)) dut2 (
      .clk(clk), .rst(rst), .din(din_a[2]), .din_valid(dv[2]), .din_ready(rd[2]),
      .sout(so[2]), .sout_valid(sv[2]), .busy(bz[2])
   );

   function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
      return msb ? w[7-i] : w[i];
   endfunction

   // Expected entries are {sout_valid, sout, busy, din_ready}.
   task automatic push_word(input int d, input logic [7:0] w, input bit msb,
                            input bit ready_last);
      for (int i = 0; i < 8; i++) begin
         sb[d].push_back({1'b1, exp_bit(w, i, msb), 1'b1, (i == 7) ? ready_last : 1'b0});
      end
   endtask

   task automatic step();
      logic [3:0] e;
      logic [3:0] obs;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (sb[i].size() > 0) begin
            e   = sb[i].pop_front();
            obs = {sv[i], so[i], bz[i], rd[i]};
            n_assert++;
            assert (obs === e) else begin
               n_fail++;
               $error("FAIL dut%0d cycle %0d v/s/b/r observed=%b expected=%b", i, cyc, obs, e);
            end
         end
      end
   endtask

   task automatic send_one(input int d, input logic [7:0] w, input bit msb);
      din_a[d] = w;
      dv[d]    = 1'b1;
      push_word(d, w, msb, 1'b1);
      sb[d].push_back(4'b0001);
      step();
      dv[d] = 1'b0;
      repeat (8) step();
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         din_a[i] = 8'h00;
         dv[i]    = 1'b0;
      end

      // Reset values, ready forced low while in reset.
      for (int i = 0; i < 3; i++) begin
         sb[i].push_back(4'b0000);
         sb[i].push_back(4'b0000);
      end
      step();
      step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) sb[i].push_back(4'b0001);
      step();

      // Basic send, MSB first.
      send_one(0, 8'hB4, 1'b1);

      // Back-to-back FF then 00 with valid held high.
      din_a[0] = 8'hFF;
      dv[0]    = 1'b1;
      push_word(0, 8'hFF, 1'b1, 1'b1);
      push_word(0, 8'h00, 1'b1, 1'b1);
      sb[0].push_back(4'b0001);
      step();
      din_a[0] = 8'h00;
      repeat (7) step();
      step();
      dv[0] = 1'b0;
      repeat (8) step();

      // Gap insertion; din changes while busy and must not disturb the first word.
      din_a[1] = 8'h96;
      dv[1]    = 1'b1;
      push_word(1, 8'h96, 1'b1, 1'b0);
      sb[1].push_back(4'b0010);
      sb[1].push_back(4'b0010);
      sb[1].push_back(4'b0001);
      push_word(1, 8'h5A, 1'b1, 1'b0);
      sb[1].push_back(4'b0010);
      sb[1].push_back(4'b0010);
      sb[1].push_back(4'b0001);
      step();
      din_a[1] = 8'h5A;
      repeat (10) step();
      step();
      dv[1] = 1'b0;
      repeat (10) step();

      // Reset after the third bit of A5, then a fresh 3C.
      din_a[0] = 8'hA5;
      dv[0]    = 1'b1;
      for (int i = 0; i < 3; i++) sb[0].push_back({1'b1, exp_bit(8'hA5, i, 1'b1), 2'b10});
      step();
      dv[0] = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) sb[i].push_back(4'b0000);
      step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) sb[i].push_back(4'b0001);
      step();
      send_one(0, 8'h3C, 1'b1);

      // LSB-first ordering.
      send_one(2, 8'h01, 1'b0);

      n_assert++;
      assert ((sb[0].size() + sb[1].size() + sb[2].size()) == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain observed=%0d leftover expected=0",
                sb[0].size() + sb[1].size() + sb[2].size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
